// File: rtl/mips_mem_access_unit_if.sv
// Request/response and data-memory port bundle for the MIPS load/store unit.
// The slave side is the unit itself; the master side is the datapath plus memory.
interface mips_mem_access_unit_if;
    // Request from the datapath
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_base;
    logic [15:0] req_offset;
    logic [31:0] req_wdata;

    // Single-cycle response to the datapath
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic [1:0]  resp_err_code;

    // Data memory port
    logic [31:0] mem_address;
    logic [31:0] write_data;
    logic [1:0]  byte_number;
    logic        sig_mem_read;
    logic        sig_mem_write;
    logic [31:0] read_data;

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_base, req_offset, req_wdata,
        output req_ready,
        output resp_valid, resp_rdata, resp_error, resp_err_code,
        output mem_address, write_data, byte_number, sig_mem_read, sig_mem_write,
        input  read_data
    );

    modport master (
        output req_valid, req_write, req_size, req_signed, req_base, req_offset, req_wdata,
        input  req_ready,
        input  resp_valid, resp_rdata, resp_error, resp_err_code,
        input  mem_address, write_data, byte_number, sig_mem_read, sig_mem_write,
        output read_data
    );
endinterface

// File: rtl/mips_mem_access_unit.sv
// Load/store initiator: computes base + sign-extended offset, validates size,
// range and alignment, pulses the memory strobe for one cycle and returns a
// one-cycle response carrying extended load data or an error code.
module mips_mem_access_unit #(
    parameter int MEM_WORDS = 256
) (
    input logic                   clk,
    input logic                   rst,
    mips_mem_access_unit_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [1:0] SIZE_WORD = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_BYTE = 2'b10;
    localparam logic [1:0] SIZE_RSVD = 2'b11;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_ALIGN = 2'b01;
    localparam logic [1:0] ERR_RANGE = 2'b10;
    localparam logic [1:0] ERR_SIZE  = 2'b11;

    localparam logic [29:0] WORD_LIMIT = 30'(MEM_WORDS);

    state_t      state;
    logic        signed_q;
    logic [31:0] ea;
    logic [1:0]  err_code;
    logic [31:0] ld_data;

    // Effective address and acceptance checks, highest-priority failure wins.
    always_comb begin
        // NOTE: every output of this block gets a value before any branch, so no latch can be inferred.
        err_code = ERR_NONE;
        ea       = bus.req_base + {{16{bus.req_offset[15]}}, bus.req_offset};
        if (bus.req_size == SIZE_RSVD) begin
            err_code = ERR_SIZE;
        end else if (ea[31:2] >= WORD_LIMIT) begin
            err_code = ERR_RANGE;
        end else if (ea[1:0] != 2'b00) begin
            err_code = ERR_ALIGN;
        end
    end

    // Sub-word sign extension; memory has already zero-extended sub-word data.
    always_comb begin
        ld_data = bus.read_data;
        case (bus.byte_number)
            SIZE_HALF: if (signed_q) ld_data = {{16{bus.read_data[15]}}, bus.read_data[15:0]};
            SIZE_BYTE: if (signed_q) ld_data = {{24{bus.read_data[7]}}, bus.read_data[7:0]};
            default:   ld_data = bus.read_data;
        endcase
    end

    // Control FSM with registered memory strobes and response outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: non-blocking assignments keep every register update on this edge independent of statement order.
            state             <= IDLE;
            signed_q          <= 1'b0;
            bus.req_ready     <= 1'b1;
            bus.resp_valid    <= 1'b0;
            bus.resp_rdata    <= '0;
            bus.resp_error    <= 1'b0;
            bus.resp_err_code <= ERR_NONE;
            bus.mem_address   <= '0;
            bus.write_data    <= '0;
            bus.byte_number   <= SIZE_WORD;
            bus.sig_mem_read  <= 1'b0;
            bus.sig_mem_write <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid && bus.req_ready) begin
                        bus.req_ready <= 1'b0;
                        if (err_code != ERR_NONE) begin
                            // Rejected request: respond next cycle, never touch memory.
                            state             <= RESP;
                            bus.resp_valid    <= 1'b1;
                            bus.resp_rdata    <= '0;
                            bus.resp_error    <= 1'b1;
                            bus.resp_err_code <= err_code;
                        end else begin
                            state             <= ACCESS;
                            signed_q          <= bus.req_signed;
                            bus.mem_address   <= {2'b00, ea[31:2]};
                            bus.byte_number   <= bus.req_size;
                            bus.write_data    <= bus.req_wdata;
                            bus.sig_mem_read  <= ~bus.req_write;
                            bus.sig_mem_write <= bus.req_write;
                        end
                    end
                end

                ACCESS: begin
                    // Load data is captured as the strobe ends; stores return zero.
                    state             <= RESP;
                    bus.resp_valid    <= 1'b1;
                    bus.resp_rdata    <= bus.sig_mem_write ? 32'h0 : ld_data;
                    bus.resp_error    <= 1'b0;
                    bus.resp_err_code <= ERR_NONE;
                    bus.mem_address   <= '0;
                    bus.write_data    <= '0;
                    bus.byte_number   <= SIZE_WORD;
                    bus.sig_mem_read  <= 1'b0;
                    bus.sig_mem_write <= 1'b0;
                end

                RESP: begin
                    state             <= IDLE;
                    bus.req_ready     <= 1'b1;
                    bus.resp_valid    <= 1'b0;
                    bus.resp_rdata    <= '0;
                    bus.resp_error    <= 1'b0;
                    bus.resp_err_code <= ERR_NONE;
                end

                default: begin
                    state         <= IDLE;
                    bus.req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
